bridge_tx_buffered: RTL and testbench

Parametrised response serializer for the host bridge. It accepts read-response words from the bus side and queues them in an internal FIFO, so back-to-back responses are not dropped. Each word is emitted as an ASCII frame: `M`, the hex digits, then the line terminator. Frames go out one byte at a time through the start/done handshake of `uart_tx`. The block generalises the fixed 16-bit, unbuffered transmit bridge with configurable data width, FIFO depth and line ending, plus flow-control and overflow reporting.

---
 rtl/bridge_tx_buffered.sv | 145 ++++++++++++++
 tb/tb_bridge_tx_buffered.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_tx_buffered.sv
// bridge_tx_buffered: queues read-response words in a small FIFO and sends
// each one to uart_tx as an ASCII frame: 'M', the hex digits MSB first,
// then CR LF or just LF.
module bridge_tx_buffered #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CRLF       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rw_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [7:0]            data_o,
  output logic                  start_o,
  input  logic                  done_i,
  output logic                  busy_o,
  output logic                  overflow_o
);

  localparam int NIB     = DATA_WIDTH / 4;
  localparam int N_BYTES = 1 + NIB + ((CRLF != 0) ? 2 : 1);
  localparam int IDX_W   = $clog2(N_BYTES);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  state_t                r_state;
  state_t                w_state_next;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_frame;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_last;

  // One nibble to its uppercase ASCII hex character.
  function automatic logic [7:0] to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte at position i of the frame for word w.
  function automatic logic [7:0] frame_byte(input logic [DATA_WIDTH-1:0] w,
                                            input logic [IDX_W-1:0] i);
    if (i == '0)
      return 8'h4D;
    else if (int'(i) <= NIB)
      return to_hex(4'(w >> (4 * (NIB - int'(i)))));
    else if ((CRLF != 0) && (int'(i) == NIB + 1))
      return 8'h0D;
    else
      return 8'h0A;
  endfunction

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // A pop in the same cycle never frees a slot: ready comes from the count alone.
  assign w_push  = valid_i && rw_i && !w_full;
  assign w_last  = (r_idx == IDX_W'(N_BYTES - 1));

  assign ready_o    = !w_full;
  assign busy_o     = (r_state != S_IDLE) || !w_empty;
  assign overflow_o = r_overflow;

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Sticky overflow: a read response that found the queue full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_overflow <= 1'b0;
    else if (valid_i && rw_i && w_full) r_overflow <= 1'b1;
  end

  // Frame word captured from the FIFO head at each pop.
  always_ff @(posedge clk) begin
    if (w_pop) r_frame <= r_mem[r_rd_ptr];
  end

  // FSM state register and byte index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop)
        r_idx <= '0;
      else if ((r_state == S_WAIT) && done_i)
        r_idx <= w_last ? '0 : (r_idx + IDX_W'(1));
    end
  end

  // Next-state logic; done_i only matters in WAIT.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (!w_empty) w_state_next = S_SEND;
      S_SEND: w_state_next = S_WAIT;
      S_WAIT: begin
        if (done_i) begin
          if (!w_last || !w_empty) w_state_next = S_SEND;
          else                     w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs: start pulse in SEND, byte held through WAIT, pop decisions.
  always_comb begin
    start_o = (r_state == S_SEND);
    data_o  = (r_state == S_IDLE) ? 8'h00 : frame_byte(r_frame, r_idx);
    w_pop   = 1'b0;
    if ((r_state == S_IDLE) && !w_empty)
      w_pop = 1'b1;
    else if ((r_state == S_WAIT) && done_i && w_last && !w_empty)
      w_pop = 1'b1;
  end

endmodule

// File: tb/tb_bridge_tx_buffered.sv
// Directed bench for bridge_tx_buffered: one default instance and one with
// 32-bit words and LF-only endings, each driven by a simple uart_tx model.
module tb_bridge_tx_buffered;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Default instance signals
  logic [15:0] d0 = '0;
  logic        rw0 = 1'b0, v0 = 1'b0, done0 = 1'b0;
  logic        rdy0, start0, busy0, ovf0;
  logic [7:0]  dout0;
  logic [7:0]  q0[$];
  int          t0[$];
  int          gap0 = 1, cnt0 = 0;

  // 32-bit / LF-only instance signals
  logic [31:0] d1 = '0;
  logic        rw1 = 1'b0, v1 = 1'b0, done1 = 1'b0;
  logic        rdy1, start1, busy1, ovf1;
  logic [7:0]  dout1;
  logic [7:0]  q1[$];
  int          gap1 = 1, cnt1 = 0;

  logic [7:0]  e[$];
  int          k;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bridge_tx_buffered u0 (
    .clk(clk), .rst(rst), .data_i(d0), .rw_i(rw0), .valid_i(v0),
    .ready_o(rdy0), .data_o(dout0), .start_o(start0), .done_i(done0),
    .busy_o(busy0), .overflow_o(ovf0)
  );

  bridge_tx_buffered #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .CRLF(0)) u1 (
    .clk(clk), .rst(rst), .data_i(d1), .rw_i(rw1), .valid_i(v1),
    .ready_o(rdy1), .data_o(dout1), .start_o(start1), .done_i(done1),
    .busy_o(busy1), .overflow_o(ovf1)
  );

  // uart_tx model for u0: log each started byte, pulse done gap0 cycles later
  always begin
    @(posedge clk); #1;
    done0 = 1'b0;
    if (rst) cnt0 = 0;
    else if (start0) begin
      q0.push_back(dout0);
      t0.push_back(cyc);
      cnt0 = gap0;
    end else if (cnt0 > 0) begin
      cnt0--;
      if (cnt0 == 0) done0 = 1'b1;
    end
  end

  // uart_tx model for u1
  always begin
    @(posedge clk); #1;
    done1 = 1'b0;
    if (rst) cnt1 = 0;
    else if (start1) begin
      q1.push_back(dout1);
      cnt1 = gap1;
    end else if (cnt1 > 0) begin
      cnt1--;
      if (cnt1 == 0) done1 = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  // Called at a negedge; holds the request for exactly one rising edge.
  task automatic push0(input logic [15:0] d, input logic rw);
    d0 = d; rw0 = rw; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0; rw0 = 1'b0;
  endtask

  task automatic push1(input logic [31:0] d, input logic rw);
    d1 = d; rw1 = rw; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; rw1 = 1'b0;
  endtask

  task automatic wait_idle(input bit which, input int bound);
    int n;
    n = 0;
    while ((which ? busy1 : busy0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(which ? busy1 : busy0), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data",  64'(dout0),  64'h00);
    chk("rst_start", 64'(start0), 64'd0);
    chk("rst_ready", 64'(rdy0),   64'd1);
    chk("rst_busy",  64'(busy0),  64'd0);
    chk("rst_ovf",   64'(ovf0),   64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rel_busy",  64'(busy0),  64'd0);
    chk("rel_ready1", 64'(rdy1),  64'd1);

    // Single frame, latency and busy fall
    q0.delete(); t0.delete(); gap0 = 1;
    push0(16'h0123, 1'b1);
    chk("lat_start_e0", 64'(start0), 64'd0);
    chk("lat_busy_e0",  64'(busy0),  64'd1);
    @(negedge clk);
    chk("lat_start_e1", 64'(start0), 64'd1);
    chk("lat_data_e1",  64'(dout0),  64'h4D);
    wait_idle(1'b0, 500);
    e = '{8'h4D, 8'h30, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
    chk_bytes("f0123", q0, e);

    // Two back-to-back frames
    q0.delete(); t0.delete();
    push0(16'h89AB, 1'b1);
    push0(16'hCDEF, 1'b1);
    wait_idle(1'b0, 500);
    e = '{8'h4D, 8'h38, 8'h39, 8'h41, 8'h42, 8'h0D, 8'h0A,
          8'h4D, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A};
    chk_bytes("b2b", q0, e);
    if (t0.size() >= 8) begin
      chk("gap_inframe", 64'(t0[1] - t0[0]), 64'(gap0 + 1));
      chk("gap_turn",    64'(t0[7] - t0[6]), 64'(gap0 + 1));
    end else chk("b2b_starts", 64'(t0.size()), 64'd14);

    // Write (rw=0) is ignored
    q0.delete(); t0.delete();
    push0(16'h1111, 1'b0);
    chk("wr_busy0", 64'(busy0), 64'd0);
    repeat (10) @(negedge clk);
    chk("wr_busy1", 64'(busy0), 64'd0);
    chk("wr_bytes", 64'(q0.size()), 64'd0);

    // Fill, overflow, and five ordered frames with a slow uart
    q0.delete(); t0.delete(); gap0 = 20;
    push0(16'h0123, 1'b1);
    push0(16'h4567, 1'b1);
    push0(16'h89AB, 1'b1);
    push0(16'hCDEF, 1'b1);
    chk("full_ready_pre", 64'(rdy0), 64'd1);
    push0(16'h1111, 1'b1);
    chk("full_ready", 64'(rdy0), 64'd0);
    chk("ovf_pre",    64'(ovf0), 64'd0);
    push0(16'h2222, 1'b1);
    chk("ovf_set",    64'(ovf0), 64'd1);
    chk("ovf_ready",  64'(rdy0), 64'd0);
    wait_idle(1'b0, 3000);
    e = '{8'h4D, 8'h30, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A,
          8'h4D, 8'h34, 8'h35, 8'h36, 8'h37, 8'h0D, 8'h0A,
          8'h4D, 8'h38, 8'h39, 8'h41, 8'h42, 8'h0D, 8'h0A,
          8'h4D, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A,
          8'h4D, 8'h31, 8'h31, 8'h31, 8'h31, 8'h0D, 8'h0A};
    chk_bytes("fill", q0, e);
    chk("ovf_sticky", 64'(ovf0), 64'd1);
    chk("fill_ready", 64'(rdy0), 64'd1);

    // 32-bit word, LF only
    q1.delete();
    push1(32'hDEADBEEF, 1'b1);
    wait_idle(1'b1, 500);
    e = '{8'h4D, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
    chk_bytes("w32", q1, e);
    chk("w32_ovf", 64'(ovf1), 64'd0);

    // Reset mid-frame with two words queued
    q0.delete(); t0.delete(); gap0 = 3;
    push0(16'hAAAA, 1'b1);
    push0(16'hBBBB, 1'b1);
    push0(16'hCCCC, 1'b1);
    k = 0;
    while (q0.size() < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("mid_bytes", 64'(q0.size()), 64'd3);
    chk("mid_busy",  64'(busy0), 64'd1);
    rst = 1'b1;
    #1;
    chk("mrst_data",  64'(dout0),  64'h00);
    chk("mrst_start", 64'(start0), 64'd0);
    chk("mrst_ready", 64'(rdy0),   64'd1);
    chk("mrst_busy",  64'(busy0),  64'd0);
    chk("mrst_ovf",   64'(ovf0),   64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q0.delete(); t0.delete();
    repeat (5) @(negedge clk);
    chk("mrst_nores", 64'(q0.size()), 64'd0);
    chk("mrst_idle",  64'(busy0), 64'd0);
    push0(16'h00FF, 1'b1);
    wait_idle(1'b0, 500);
    e = '{8'h4D, 8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A};
    chk_bytes("post_rst", q0, e);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
